// File: rtl/video_timing_decoder_pkg.sv
// Shared types and limits for the video timing decoder.
// Provides: FSM state enum, horizontal/vertical result structs, counter
// widths and saturation limits used by the top and the span meter.
package video_timing_decoder_pkg;

  localparam int unsigned H_CNT_W    = 8;
  localparam int unsigned V_CNT_W    = 10;
  localparam int unsigned H_SW_W     = 4;
  localparam int unsigned V_SW_W     = 5;
  localparam int unsigned H_CNT_MAX  = 255;
  localparam int unsigned V_CNT_MAX  = 1023;
  localparam int unsigned H_SW_LIMIT = 16;
  localparam int unsigned V_SW_LIMIT = 31;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [H_CNT_W-1:0] total;
    logic [H_CNT_W-1:0] displayed;
    logic [H_CNT_W-1:0] sync_start;
    logic [H_SW_W-1:0]  sync_width;
  } h_result_t;

  typedef struct packed {
    logic [V_CNT_W-1:0] total;
    logic [V_CNT_W-1:0] displayed;
    logic [V_CNT_W-1:0] sync_start;
    logic [V_SW_W-1:0]  sync_width;
  } v_result_t;

endpackage

// File: rtl/video_timing_decoder_timing_span_meter.sv
// Measures one span (a line or a frame) between consecutive start edges.
// Ports:
//   cclk_i, reset_i   : clock, async active-high reset
//   en                : count enable (every cycle for h, scanline tick for v)
//   start             : span start edge; its cycle is index 0
//   active, sync      : display-enable and sync strobes (levels)
//   total_c           : index of the closing start edge minus 1
//   displayed         : index of the active fall (0 if none)
//   sync_start        : index of the sync rise (0 if none)
//   sync_width_c      : enabled cycles with sync high, SW_SAT when over limit
//   sync_over_c       : sync width exceeded SW_LIMIT
//   cnt_sat_c         : span counter sits at CNT_MAX
// The capture fields describe the span that closes on the cycle start is high.
module video_timing_decoder_timing_span_meter
  import video_timing_decoder_pkg::*;
#(
  parameter int unsigned CNT_W    = H_CNT_W,
  parameter int unsigned SW_W     = H_SW_W,
  parameter int unsigned CNT_MAX  = H_CNT_MAX,
  parameter int unsigned SW_LIMIT = H_SW_LIMIT,
  parameter int unsigned SW_SAT   = 0
) (
  input  logic             cclk_i,
  input  logic             reset_i,
  input  logic             en,
  input  logic             start,
  input  logic             active,
  input  logic             sync,
  output logic [CNT_W-1:0] total_c,
  output logic [CNT_W-1:0] displayed,
  output logic [CNT_W-1:0] sync_start,
  output logic [SW_W-1:0]  sync_width_c,
  output logic             sync_over_c,
  output logic             cnt_sat_c
);

  localparam int unsigned WC_W = SW_W + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_c;
  logic [WC_W-1:0]  wcnt_q;
  logic             active_q;
  logic             sync_q;
  logic             active_fall;
  logic             sync_rise;

  // Index of the current cycle within the span; a start cycle is index 0.
  assign idx_c       = start ? '0 : cnt_q;
  assign active_fall = ~active & active_q;
  assign sync_rise   = sync & ~sync_q;

  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      wcnt_q     <= '0;
      active_q   <= 1'b0;
      sync_q     <= 1'b0;
      displayed  <= '0;
      sync_start <= '0;
    end else begin
      active_q <= active;
      sync_q   <= sync;
      if (en) begin
        cnt_q <= (idx_c == CNT_W'(CNT_MAX)) ? idx_c : idx_c + CNT_W'(1);
      end else if (start) begin
        cnt_q <= '0;
      end
      // Missing edges leave 0 in the new span's captures.
      if (start) begin
        displayed  <= '0;
        sync_start <= '0;
      end
      if (active_fall) displayed <= idx_c;
      if (sync_rise) sync_start <= idx_c;
      // Width counter stops one past the limit so over-width stays visible.
      if (start) begin
        wcnt_q <= WC_W'(en & sync);
      end else if (en && sync && (wcnt_q <= WC_W'(SW_LIMIT))) begin
        wcnt_q <= wcnt_q + WC_W'(1);
      end
    end
  end

  assign total_c      = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign sync_over_c  = (wcnt_q > WC_W'(SW_LIMIT));
  assign sync_width_c = sync_over_c ? SW_W'(SW_SAT) : wcnt_q[SW_W-1:0];
  assign cnt_sat_c    = (cnt_q == CNT_W'(CNT_MAX));

endmodule

// File: rtl/video_timing_decoder.sv
// Passive video timing decoder: recovers horizontal (characters) and vertical
// (scanlines) timing from active/sync strobes and reports lock once two
// consecutive frames measure identically.
// Ports:
//   cclk_i, reset_i             : character clock, async active-high reset
//   h_active_i, h_sync_i        : horizontal display enable / sync
//   v_active_i, v_sync_i        : vertical display enable / sync
//   h_*_o, v_*_o                : published timing fields
//   frame_o                     : one-cycle pulse on publish
//   locked_o                    : timing stable
//   error_o                     : sticky, cleared by reset only
// Build option: VIDEO_TIMING_DECODER_SYNC_EN adds 2-flop input synchronizers.
module video_timing_decoder
  import video_timing_decoder_pkg::*;
(
  input  logic               cclk_i,
  input  logic               reset_i,
  input  logic               h_active_i,
  input  logic               h_sync_i,
  input  logic               v_active_i,
  input  logic               v_sync_i,
  output logic [H_CNT_W-1:0] h_total_o,
  output logic [H_CNT_W-1:0] h_displayed_o,
  output logic [H_CNT_W-1:0] h_sync_start_o,
  output logic [H_SW_W-1:0]  h_sync_width_o,
  output logic [V_CNT_W-1:0] v_total_o,
  output logic [V_CNT_W-1:0] v_displayed_o,
  output logic [V_CNT_W-1:0] v_sync_start_o,
  output logic [V_SW_W-1:0]  v_sync_width_o,
  output logic               frame_o,
  output logic               locked_o,
  output logic               error_o
);

  logic h_active, h_sync, v_active, v_sync;

`ifdef VIDEO_TIMING_DECODER_SYNC_EN
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two-flop synchronizers for strobes from a foreign clock domain.
  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {h_active_i, h_sync_i, v_active_i, v_sync_i};
      sync_q <= meta_q;
    end
  end
  assign {h_active, h_sync, v_active, v_sync} = sync_q;
`else
  assign {h_active, h_sync, v_active, v_sync} = {h_active_i, h_sync_i, v_active_i, v_sync_i};
`endif

  logic h_active_q, h_sync_q, v_active_q;
  logic line_start, tick, frame_start;

  // Edge detection for line start, scanline tick and frame start.
  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) begin
      h_active_q <= 1'b0;
      h_sync_q   <= 1'b0;
      v_active_q <= 1'b0;
    end else begin
      h_active_q <= h_active;
      h_sync_q   <= h_sync;
      v_active_q <= v_active;
    end
  end

  assign line_start  = h_active & ~h_active_q;
  assign tick        = h_sync & ~h_sync_q;
  assign frame_start = v_active & ~v_active_q;

  h_result_t h_line_c;
  v_result_t v_frame_c;
  logic      h_over_c, v_over_c, h_sat_c, v_sat_c;

  video_timing_decoder_timing_span_meter #(
    .CNT_W(H_CNT_W), .SW_W(H_SW_W), .CNT_MAX(H_CNT_MAX),
    .SW_LIMIT(H_SW_LIMIT), .SW_SAT(0)
  ) u_h_meter (
    .cclk_i      (cclk_i),
    .reset_i     (reset_i),
    .en          (1'b1),
    .start       (line_start),
    .active      (h_active),
    .sync        (h_sync),
    .total_c     (h_line_c.total),
    .displayed   (h_line_c.displayed),
    .sync_start  (h_line_c.sync_start),
    .sync_width_c(h_line_c.sync_width),
    .sync_over_c (h_over_c),
    .cnt_sat_c   (h_sat_c)
  );

  video_timing_decoder_timing_span_meter #(
    .CNT_W(V_CNT_W), .SW_W(V_SW_W), .CNT_MAX(V_CNT_MAX),
    .SW_LIMIT(V_SW_LIMIT), .SW_SAT(V_SW_LIMIT)
  ) u_v_meter (
    .cclk_i      (cclk_i),
    .reset_i     (reset_i),
    .en          (tick),
    .start       (frame_start),
    .active      (v_active),
    .sync        (v_sync),
    .total_c     (v_frame_c.total),
    .displayed   (v_frame_c.displayed),
    .sync_start  (v_frame_c.sync_start),
    .sync_width_c(v_frame_c.sync_width),
    .sync_over_c (v_over_c),
    .cnt_sat_c   (v_sat_c)
  );

  h_result_t shadow_q;
  logic      first_pending_q;
  logic      frame_bad_q;
  logic      line_bad_c;
  logic      bad_c;

  // A closing line is bad if over-width or, after the first line, unlike the shadow.
  assign line_bad_c = line_start &
                      (h_over_c | (~first_pending_q & (h_line_c != shadow_q)));
  // Includes the line closing in the frame-start cycle, so the last line counts.
  assign bad_c      = frame_bad_q | line_bad_c | (frame_start & v_over_c);

  // Shadow of the first line of each frame and the per-frame bad flag.
  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_q        <= '0;
      first_pending_q <= 1'b0;
      frame_bad_q     <= 1'b0;
    end else begin
      if (line_start && first_pending_q) begin
        shadow_q        <= h_line_c;
        first_pending_q <= 1'b0;
      end
      if (frame_start) first_pending_q <= 1'b1;
      frame_bad_q <= frame_start ? 1'b0 : (frame_bad_q | line_bad_c);
    end
  end

  state_t    state_q, state_d;
  h_result_t h_q;
  v_result_t v_q;
  logic      frame_q, locked_q, error_q;
  logic      compare_c, timeout_c, publish_c, err_set_c;

  assign compare_c = (shadow_q == h_q) && (v_frame_c == v_q) && !bad_c;
  assign timeout_c = (h_sat_c & ~line_start) | (v_sat_c & ~frame_start);

  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  // Lock FSM: next state, publish strobe and error set.
  always_comb begin
    state_d   = state_q;
    publish_c = 1'b0;
    err_set_c = 1'b0;
    case (state_q)
      SEARCH: begin
        if (frame_start) state_d = MEASURE;
      end
      MEASURE: begin
        if (frame_start) begin
          publish_c = 1'b1;
          if (compare_c) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (frame_start) begin
          publish_c = 1'b1;
          if (!compare_c) begin
            state_d   = MEASURE;
            err_set_c = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    if (timeout_c) begin
      state_d   = SEARCH;
      publish_c = 1'b0;
      err_set_c = 1'b1;
    end
  end

  // Published results and status flags.
  always_ff @(posedge cclk_i or posedge reset_i) begin
    if (reset_i) begin
      h_q      <= '0;
      v_q      <= '0;
      frame_q  <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      frame_q  <= publish_c;
      locked_q <= (state_d == LOCKED);
      if (publish_c) begin
        h_q <= shadow_q;
        v_q <= v_frame_c;
      end
      if (err_set_c) error_q <= 1'b1;
    end
  end

  assign h_total_o      = h_q.total;
  assign h_displayed_o  = h_q.displayed;
  assign h_sync_start_o = h_q.sync_start;
  assign h_sync_width_o = h_q.sync_width;
  assign v_total_o      = v_q.total;
  assign v_displayed_o  = v_q.displayed;
  assign v_sync_start_o = v_q.sync_start;
  assign v_sync_width_o = v_q.sync_width;
  assign frame_o        = frame_q;
  assign locked_o       = locked_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder: synthetic video timings are
// generated character by character and the published fields, lock and
// error behaviour are compared against hand-computed values.
module tb_video_timing_decoder;
  import video_timing_decoder_pkg::*;

  logic       cclk_i, reset_i;
  logic       h_active_i, h_sync_i, v_active_i, v_sync_i;
  logic [7:0] h_total_o, h_displayed_o, h_sync_start_o;
  logic [3:0] h_sync_width_o;
  logic [9:0] v_total_o, v_displayed_o, v_sync_start_o;
  logic [4:0] v_sync_width_o;
  logic       frame_o, locked_o, error_o;

  video_timing_decoder dut (
    .cclk_i(cclk_i), .reset_i(reset_i),
    .h_active_i(h_active_i), .h_sync_i(h_sync_i),
    .v_active_i(v_active_i), .v_sync_i(v_sync_i),
    .h_total_o(h_total_o), .h_displayed_o(h_displayed_o),
    .h_sync_start_o(h_sync_start_o), .h_sync_width_o(h_sync_width_o),
    .v_total_o(v_total_o), .v_displayed_o(v_displayed_o),
    .v_sync_start_o(v_sync_start_o), .v_sync_width_o(v_sync_width_o),
    .frame_o(frame_o), .locked_o(locked_o), .error_o(error_o)
  );

  initial cclk_i = 1'b0;
  always #5 cclk_i = ~cclk_i;

  typedef struct {
    int chars, h_act, hss, hsw, lines, v_act, vss, vsw, bad_last;
  } cfg_t;

  cfg_t nom, sml, sml16, sml17, sml_short, sml_last;
  int   n_checks, n_pass, pulses;

  // One character of the given timing; samples frame_o 1 unit after the edge.
  task automatic drive(input cfg_t c, input int l, input int ch);
    int ha;
    ha = (c.bad_last != 0 && l == c.lines - 1) ? c.h_act - 1 : c.h_act;
    h_active_i = (ch < ha);
    h_sync_i   = (ch >= c.hss) && (ch < c.hss + c.hsw);
    v_active_i = (l < c.v_act);
    v_sync_i   = (l >= c.vss) && (l < c.vss + c.vsw);
    @(posedge cclk_i); #1;
    if (frame_o) pulses++;
  endtask

  task automatic start_frame(input cfg_t c);
    drive(c, 0, 0);
  endtask

  // Rest of a frame after its first character.
  task automatic run_frame(input cfg_t c);
    for (int l = 0; l < c.lines; l++)
      for (int ch = 0; ch < c.chars; ch++)
        if (l != 0 || ch != 0) drive(c, l, ch);
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    h_active_i = 1'b0; h_sync_i = 1'b0; v_active_i = 1'b0; v_sync_i = 1'b0;
    repeat (3) @(posedge cclk_i);
    #1;
    reset_i = 1'b0;
    pulses  = 0;
  endtask

  // Reset, then three frame starts of the small timing.
  task automatic lock_small(input cfg_t c);
    apply_reset();
    start_frame(c); run_frame(c);
    start_frame(c); run_frame(c);
    start_frame(c);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    h_active_i = 1'b0; h_sync_i = 1'b0; v_active_i = 1'b0; v_sync_i = 1'b0;
    repeat (2) @(posedge cclk_i);
    #1;
    n_checks++;
    if ({h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o,
         v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o} !== 63'd0)
      $display("FAIL reset_fields got %h exp 0", {h_total_o, h_displayed_o, v_total_o, v_displayed_o});
    else n_pass++;
    n_checks++;
    if ({frame_o, locked_o, error_o} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {frame_o, locked_o, error_o});
    else n_pass++;
    n_checks++;
    if (dut.state_q !== SEARCH) $display("FAIL reset_state got %0d exp %0d", dut.state_q, SEARCH);
    else n_pass++;
  endtask

  task automatic test_nominal();
    apply_reset();
    start_frame(nom);
    n_checks++;
    if (frame_o !== 1'b0 || dut.state_q !== MEASURE)
      $display("FAIL nom_first_start got frame=%b state=%0d exp frame=0 state=1", frame_o, dut.state_q);
    else n_pass++;
    run_frame(nom);
    start_frame(nom);
    n_checks++;
    if (frame_o !== 1'b1) $display("FAIL nom_frame2 got %b exp 1", frame_o); else n_pass++;
    n_checks++;
    if ({h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o} !== {8'd63, 8'd40, 8'd48, 4'd5})
      $display("FAIL nom_h got %0d/%0d/%0d/%0d exp 63/40/48/5",
               h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o);
    else n_pass++;
    n_checks++;
    if ({v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o} !== {10'd263, 10'd200, 10'd224, 5'd8})
      $display("FAIL nom_v got %0d/%0d/%0d/%0d exp 263/200/224/8",
               v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o);
    else n_pass++;
    n_checks++;
    if (locked_o !== 1'b0) $display("FAIL nom_unlocked_2nd got %b exp 0", locked_o); else n_pass++;
    run_frame(nom);
    start_frame(nom);
    n_checks++;
    if ({frame_o, locked_o, error_o} !== 3'b110)
      $display("FAIL nom_lock got frame/locked/error %b exp 110", {frame_o, locked_o, error_o});
    else n_pass++;
    n_checks++;
    if (pulses !== 2) $display("FAIL nom_pulses got %0d exp 2", pulses); else n_pass++;
  endtask

  task automatic test_hsync_width();
    lock_small(sml16);
    n_checks++;
    if ({locked_o, error_o} !== 2'b10) $display("FAIL hsw16_lock got %b exp 10", {locked_o, error_o});
    else n_pass++;
    n_checks++;
    if ({h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o} !== {8'd39, 8'd16, 8'd20, 4'd0})
      $display("FAIL hsw16_h got %0d/%0d/%0d/%0d exp 39/16/20/0",
               h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o);
    else n_pass++;
    lock_small(sml17);
    n_checks++;
    if ({locked_o, error_o} !== 2'b00) $display("FAIL hsw17_nolock got %b exp 00", {locked_o, error_o});
    else n_pass++;
    n_checks++;
    if (h_sync_width_o !== 4'd0 || pulses !== 2)
      $display("FAIL hsw17_width got width=%0d pulses=%0d exp width=0 pulses=2", h_sync_width_o, pulses);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    lock_small(sml);
    n_checks++;
    if (locked_o !== 1'b1) $display("FAIL short_prelock got %b exp 1", locked_o); else n_pass++;
    run_frame(sml_short);
    start_frame(sml);
    n_checks++;
    if ({v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o} !== {10'd18, 10'd12, 10'd14, 5'd2})
      $display("FAIL short_v got %0d/%0d/%0d/%0d exp 18/12/14/2",
               v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== MEASURE || {locked_o, error_o} !== 2'b01)
      $display("FAIL short_unlock got state=%0d locked/error=%b exp state=1 01", dut.state_q, {locked_o, error_o});
    else n_pass++;
    run_frame(sml);
    start_frame(sml);
    n_checks++;
    if (locked_o !== 1'b0) $display("FAIL short_relock_early got %b exp 0", locked_o); else n_pass++;
    run_frame(sml);
    start_frame(sml);
    n_checks++;
    if (locked_o !== 1'b1 || v_total_o !== 10'd19)
      $display("FAIL short_relock got locked=%b vtotal=%0d exp locked=1 vtotal=19", locked_o, v_total_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    lock_small(sml);
    for (int k = 1; k <= 300; k++) begin
      h_active_i = 1'b0; h_sync_i = 1'b0; v_active_i = 1'b1; v_sync_i = 1'b0;
      @(posedge cclk_i); #1;
      if (k == 254) begin
        n_checks++;
        if (locked_o !== 1'b1) $display("FAIL timeout_early got %b exp 1", locked_o); else n_pass++;
      end
      if (k == 255) begin
        n_checks++;
        if (locked_o !== 1'b0 || error_o !== 1'b1 || dut.state_q !== SEARCH)
          $display("FAIL timeout_hit got locked=%b error=%b state=%0d exp 0 1 0", locked_o, error_o, dut.state_q);
        else n_pass++;
      end
    end
    n_checks++;
    if (dut.state_q !== SEARCH) $display("FAIL timeout_hold got %0d exp 0", dut.state_q); else n_pass++;
  endtask

  task automatic test_coincident();
    lock_small(sml);
    n_checks++;
    if ({v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o} !== {10'd19, 10'd12, 10'd14, 5'd2})
      $display("FAIL coin_v got %0d/%0d/%0d/%0d exp 19/12/14/2",
               v_total_o, v_displayed_o, v_sync_start_o, v_sync_width_o);
    else n_pass++;
    n_checks++;
    if ({h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o} !== {8'd39, 8'd16, 8'd20, 4'd3})
      $display("FAIL coin_h got %0d/%0d/%0d/%0d exp 39/16/20/3",
               h_total_o, h_displayed_o, h_sync_start_o, h_sync_width_o);
    else n_pass++;
    // Only the last line differs; it closes in the frame-start cycle.
    run_frame(sml_last);
    start_frame(sml);
    n_checks++;
    if ({locked_o, error_o} !== 2'b01 || v_total_o !== 10'd19)
      $display("FAIL coin_last_line got locked/error=%b vtotal=%0d exp 01 19", {locked_o, error_o}, v_total_o);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    lock_small(sml);
    for (int l = 0; l < 10; l++)
      for (int ch = 0; ch < sml.chars; ch++)
        if (l != 0 || ch != 0) drive(sml, l, ch);
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({h_total_o, v_total_o, frame_o, locked_o, error_o} !== 21'd0 || dut.state_q !== SEARCH)
      $display("FAIL midreset_clear got h=%0d v=%0d flags=%b exp 0 0 000",
               h_total_o, v_total_o, {frame_o, locked_o, error_o});
    else n_pass++;
    h_active_i = 1'b0; h_sync_i = 1'b0; v_active_i = 1'b0; v_sync_i = 1'b0;
    repeat (2) @(posedge cclk_i);
    #1;
    reset_i = 1'b0;
    pulses  = 0;
    start_frame(sml); run_frame(sml);
    start_frame(sml);
    n_checks++;
    if (locked_o !== 1'b0 || pulses !== 1)
      $display("FAIL midreset_2nd got locked=%b pulses=%0d exp 0 1", locked_o, pulses);
    else n_pass++;
    run_frame(sml);
    start_frame(sml);
    n_checks++;
    if ({locked_o, error_o} !== 2'b10 || h_total_o !== 8'd39 || v_total_o !== 10'd19)
      $display("FAIL midreset_relock got locked/error=%b h=%0d v=%0d exp 10 39 19",
               {locked_o, error_o}, h_total_o, v_total_o);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; pulses = 0;
    reset_i = 1'b1;
    h_active_i = 1'b0; h_sync_i = 1'b0; v_active_i = 1'b0; v_sync_i = 1'b0;
    nom       = '{64, 40, 48, 5, 264, 200, 224, 8, 0};
    sml       = '{40, 16, 20, 3, 20, 12, 14, 2, 0};
    sml16     = '{40, 16, 20, 16, 20, 12, 14, 2, 0};
    sml17     = '{40, 16, 20, 17, 20, 12, 14, 2, 0};
    sml_short = '{40, 16, 20, 3, 19, 12, 14, 2, 0};
    sml_last  = '{40, 16, 20, 3, 20, 12, 14, 2, 1};
    test_reset();
    test_nominal();
    test_hsync_width();
    test_short_frame();
    test_timeout();
    test_coincident();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
